// File: rtl/top_fpga.sv
// Single-cycle 8-bit teaching CPU: four registers, zero flag and a fixed 256x8 program ROM.
// Every clock fetches rom[PC] and rom[PC+1] and retires one whole instruction.
module top_fpga (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] LED_PC,
  output logic [7:0] LED_R0,
  output logic [7:0] LED_R1,
  output logic [7:0] LED_R2,
  output logic [7:0] LED_R3,
  output logic       LED_ZERO
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [7:0]      r_pc;
  logic [7:0]      w_nxt_pc;
  logic [3:0][7:0] r_regs;
  logic [3:0][7:0] w_nxt_regs;
  logic            r_zero;
  logic            w_nxt_zero;

  logic [7:0] w_pc_inc1;
  logic [7:0] w_pc_inc2;
  logic [7:0] w_ins;
  logic [7:0] w_opr;
  logic [3:0] w_opcode;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [7:0] w_res;
  logic       w_wr;
  logic       w_setz;

  // Default program: counts R1 down from 3 while R0 holds 5+3, then parks on HLT.
  function automatic logic [7:0] rom_byte(input logic [7:0] addr);
    case (addr)
      8'h00:   rom_byte = 8'h10;
      8'h01:   rom_byte = 8'h05;
      8'h02:   rom_byte = 8'h14;
      8'h03:   rom_byte = 8'h03;
      8'h04:   rom_byte = 8'h31;
      8'h05:   rom_byte = 8'h28;
      8'h06:   rom_byte = 8'h94;
      8'h07:   rom_byte = 8'hC0;
      8'h08:   rom_byte = 8'h06;
      8'h09:   rom_byte = 8'h1C;
      8'h0A:   rom_byte = 8'hAA;
      8'h0B:   rom_byte = 8'hF0;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  assign w_pc_inc1 = r_pc + 8'd1;
  assign w_pc_inc2 = r_pc + 8'd2;
  assign w_ins     = rom_byte(r_pc);
  assign w_opr     = rom_byte(w_pc_inc1);
  assign w_opcode  = w_ins[7:4];
  assign w_rd      = w_ins[3:2];
  assign w_rs      = w_ins[1:0];
  // Operands come from pre-edge registers, so rd==rs reads the same old value twice.
  assign w_a       = r_regs[w_rd];
  assign w_b       = r_regs[w_rs];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_pc    <= 8'h00;
      r_regs  <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pc    <= w_nxt_pc;
      r_regs  <= w_nxt_regs;
      r_zero  <= w_nxt_zero;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = w_pc_inc1;
    w_nxt_regs  = r_regs;
    w_nxt_zero  = r_zero;
    w_res       = 8'h00;
    w_wr        = 1'b0;
    w_setz      = 1'b0;

    if (r_state == ST_HALT) begin
      w_nxt_pc = r_pc;
    end else begin
      case (w_opcode)
        4'h1: begin
          w_res    = w_opr;
          w_wr     = 1'b1;
          w_nxt_pc = w_pc_inc2;
        end
        4'h2: begin
          w_res = w_b;
          w_wr  = 1'b1;
        end
        4'h3: begin w_res = w_a + w_b;  w_wr = 1'b1; w_setz = 1'b1; end
        4'h4: begin w_res = w_a - w_b;  w_wr = 1'b1; w_setz = 1'b1; end
        4'h5: begin w_res = w_a & w_b;  w_wr = 1'b1; w_setz = 1'b1; end
        4'h6: begin w_res = w_a | w_b;  w_wr = 1'b1; w_setz = 1'b1; end
        4'h7: begin w_res = w_a ^ w_b;  w_wr = 1'b1; w_setz = 1'b1; end
        4'h8: begin w_res = w_a + 8'd1; w_wr = 1'b1; w_setz = 1'b1; end
        4'h9: begin w_res = w_a - 8'd1; w_wr = 1'b1; w_setz = 1'b1; end
        4'hA: w_nxt_pc = w_opr;
        4'hB: w_nxt_pc = r_zero ? w_opr : w_pc_inc2;
        4'hC: w_nxt_pc = r_zero ? w_pc_inc2 : w_opr;
        4'hF: begin
          w_nxt_pc    = r_pc;
          w_nxt_state = ST_HALT;
        end
        default: ;
      endcase
    end

    if (w_wr) w_nxt_regs[w_rd] = w_res;
    if (w_setz) w_nxt_zero = (w_res == 8'h00);
  end

  assign LED_PC   = r_pc;
  assign LED_R0   = r_regs[0];
  assign LED_R1   = r_regs[1];
  assign LED_R2   = r_regs[2];
  assign LED_R3   = r_regs[3];
  assign LED_ZERO = r_zero;

endmodule

// File: tb/tb_top_fpga.sv
// Bench for top_fpga: default-program vector table, reset cases, alternate ROM images
// substituted over the fetch wires, and random programs against an instruction-level model.
module tb_top_fpga;

  logic       clk;
  logic       rst;
  logic [7:0] LED_PC, LED_R0, LED_R1, LED_R2, LED_R3;
  logic       LED_ZERO;

  int checks = 0;
  int errors = 0;

  top_fpga dut (
    .clk      (clk),
    .rst      (rst),
    .LED_PC   (LED_PC),
    .LED_R0   (LED_R0),
    .LED_R1   (LED_R1),
    .LED_R2   (LED_R2),
    .LED_R3   (LED_R3),
    .LED_ZERO (LED_ZERO)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- program image seen by model (and by DUT when substituted) ----------------
  logic [7:0] cur_rom [256];
  logic [7:0] tb_pc1;
  logic [7:0] tb_ins;
  logic [7:0] tb_opr;
  assign tb_pc1 = LED_PC + 8'd1;
  assign tb_ins = cur_rom[LED_PC];
  assign tb_opr = cur_rom[tb_pc1];

  // ---------------- reference model (instruction-set level) ----------------
  int m_pc, m_z, m_halt;
  int m_r[4];

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_halt = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endtask

  task automatic model_step();
    int ins, opr, op, rd, rs, a, b, res, nxt;
    bit wr, setz;
    if (m_halt != 0) return;
    ins = int'(cur_rom[m_pc]);
    opr = int'(cur_rom[(m_pc + 1) % 256]);
    op = ins / 16; rd = (ins / 4) % 4; rs = ins % 4;
    a = m_r[rd]; b = m_r[rs];
    wr = 0; setz = 0; res = 0;
    nxt = (m_pc + 1) % 256;
    case (op)
      1:  begin res = opr; wr = 1; nxt = (m_pc + 2) % 256; end
      2:  begin res = b; wr = 1; end
      3:  begin res = (a + b) % 256;       wr = 1; setz = 1; end
      4:  begin res = (a - b + 256) % 256; wr = 1; setz = 1; end
      5:  begin res = a & b;               wr = 1; setz = 1; end
      6:  begin res = a | b;               wr = 1; setz = 1; end
      7:  begin res = a ^ b;               wr = 1; setz = 1; end
      8:  begin res = (a + 1) % 256;       wr = 1; setz = 1; end
      9:  begin res = (a + 255) % 256;     wr = 1; setz = 1; end
      10: nxt = opr;
      11: nxt = (m_z != 0) ? opr : (m_pc + 2) % 256;
      12: nxt = (m_z == 0) ? opr : (m_pc + 2) % 256;
      15: begin nxt = m_pc; m_halt = 1; end
      default: ;
    endcase
    if (wr) m_r[rd] = res;
    if (setz) m_z = (res == 0) ? 1 : 0;
    m_pc = nxt;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_exp(input string name, input logic [7:0] pc, input logic [7:0] r0,
                           input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3,
                           input logic z);
    check8({name, ".pc"}, LED_PC, pc);
    check8({name, ".r0"}, LED_R0, r0);
    check8({name, ".r1"}, LED_R1, r1);
    check8({name, ".r2"}, LED_R2, r2);
    check8({name, ".r3"}, LED_R3, r3);
    check8({name, ".z"}, {7'd0, LED_ZERO}, {7'd0, z});
  endtask

  task automatic check_model(input string name);
    check_exp(name, 8'(m_pc), 8'(m_r[0]), 8'(m_r[1]), 8'(m_r[2]), 8'(m_r[3]), m_z[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_reset();
      @(negedge clk);
      check_exp($sformatf("reset_e%0d", i + 1), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    rst = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) cur_rom[i] = 8'h00;
  endtask

  // ---------------- default-program vector table ----------------
  typedef struct {
    logic [7:0] pc, r0, r1, r2, r3;
    logic       z;
  } vec_t;
  vec_t dflt_tab[13];

  task automatic run_table(input string tag, input int count);
    int taken = 0;
    logic [7:0] prev_pc;
    for (int i = 0; i < count; i++) begin
      prev_pc = LED_PC;
      step();
      check_exp($sformatf("%s_n%0d", tag, i + 1), dflt_tab[i].pc, dflt_tab[i].r0,
                dflt_tab[i].r1, dflt_tab[i].r2, dflt_tab[i].r3, dflt_tab[i].z);
      if (prev_pc == 8'h07 && LED_PC == 8'h06) taken++;
    end
    if (count == 13) check8({tag, "_jnz_taken"}, 8'(taken), 8'd2);
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    dflt_tab[0]  = '{8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0};
    dflt_tab[1]  = '{8'h04, 8'h05, 8'h03, 8'h00, 8'h00, 1'b0};
    dflt_tab[2]  = '{8'h05, 8'h08, 8'h03, 8'h00, 8'h00, 1'b0};
    dflt_tab[3]  = '{8'h06, 8'h08, 8'h03, 8'h08, 8'h00, 1'b0};
    dflt_tab[4]  = '{8'h07, 8'h08, 8'h02, 8'h08, 8'h00, 1'b0};
    dflt_tab[5]  = '{8'h06, 8'h08, 8'h02, 8'h08, 8'h00, 1'b0};
    dflt_tab[6]  = '{8'h07, 8'h08, 8'h01, 8'h08, 8'h00, 1'b0};
    dflt_tab[7]  = '{8'h06, 8'h08, 8'h01, 8'h08, 8'h00, 1'b0};
    dflt_tab[8]  = '{8'h07, 8'h08, 8'h00, 8'h08, 8'h00, 1'b1};
    dflt_tab[9]  = '{8'h09, 8'h08, 8'h00, 8'h08, 8'h00, 1'b1};
    dflt_tab[10] = '{8'h0B, 8'h08, 8'h00, 8'h08, 8'hAA, 1'b1};
    dflt_tab[11] = '{8'h0B, 8'h08, 8'h00, 8'h08, 8'hAA, 1'b1};
    dflt_tab[12] = '{8'h0B, 8'h08, 8'h00, 8'h08, 8'hAA, 1'b1};

    // Model mirrors the built-in program while the DUT fetches from its own ROM.
    clear_rom();
    cur_rom[8'h00] = 8'h10; cur_rom[8'h01] = 8'h05; cur_rom[8'h02] = 8'h14;
    cur_rom[8'h03] = 8'h03; cur_rom[8'h04] = 8'h31; cur_rom[8'h05] = 8'h28;
    cur_rom[8'h06] = 8'h94; cur_rom[8'h07] = 8'hC0; cur_rom[8'h08] = 8'h06;
    cur_rom[8'h09] = 8'h1C; cur_rom[8'h0A] = 8'hAA; cur_rom[8'h0B] = 8'hF0;

    @(negedge clk);
    do_reset(3);
    run_table("dflt", 13);
    for (int i = 0; i < 4; i++) begin
      step();
      check_model($sformatf("halt_hold%0d", i));
    end

    // Reset while halted, then mid-run reset asserted at edge 7.
    do_reset(2);
    run_table("pre_mid", 6);
    do_reset(1);
    run_table("after_mid", 13);

    // Alternate ROM images substituted over the fetch path.
    force dut.w_ins = tb_ins;
    force dut.w_opr = tb_opr;

    clear_rom();
    cur_rom[8'h00] = 8'h10; cur_rom[8'h01] = 8'hFF; cur_rom[8'h02] = 8'h80;
    cur_rom[8'h03] = 8'h90; cur_rom[8'h04] = 8'h40; cur_rom[8'h05] = 8'hF0;
    do_reset(1);
    step(); check_exp("arith_ldi", 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    step(); check_exp("arith_inc", 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    step(); check_exp("arith_dec", 8'h04, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    step(); check_exp("arith_sub", 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    step(); check_exp("arith_hlt", 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

    clear_rom();
    cur_rom[8'h00] = 8'hA0; cur_rom[8'h01] = 8'hFF;
    do_reset(1);
    step(); check_exp("wrap_jmp", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    step(); check_exp("wrap_nop", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    step(); check_exp("wrap_jmp2", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // LDI at 0xFF takes its immediate from 0x00 and lands on 0x01 (a HLT byte).
    cur_rom[8'hFF] = 8'h18;
    do_reset(1);
    step(); check_exp("wrap_ldi_jmp", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    step(); check_exp("wrap_ldi", 8'h01, 8'h00, 8'h00, 8'hA0, 8'h00, 1'b0);
    step(); check_exp("wrap_ldi_hlt", 8'h01, 8'h00, 8'h00, 8'hA0, 8'h00, 1'b0);

    // Random programs, HLT made rare so most runs execute all 40 steps.
    for (int p = 0; p < 20; p++) begin
      for (int a = 0; a < 256; a++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b[7:4] == 4'hF && $urandom_range(0, 7) != 0) b[7:4] = 4'h3;
        cur_rom[a] = b;
      end
      do_reset(1);
      for (int s = 0; s < 40; s++) begin
        step();
        check_model($sformatf("rand_p%0d_s%0d", p, s));
      end
      if ($urandom_range(0, 1) == 1) begin
        do_reset(1);
        for (int s = 0; s < 5; s++) begin
          step();
          check_model($sformatf("rand_rst_p%0d_s%0d", p, s));
        end
      end
    end

    release dut.w_ins;
    release dut.w_opr;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
